// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle sequencer for the MIPS-subset core (R-type, ORI, LW, SW,
//   BEQ, J). One FSM walks each instruction through fetch / decode /
//   execute / memory / writeback and issues the datapath strobes for the
//   shared ALU, unified memory and IR/PC/ALUOut registers. It also counts
//   retired instructions and flags unknown opcodes.
//
// Ports
//   clk, reset       rising-edge clock, async active-high reset
//   op, funct        IR[31:26] / IR[5:0] (op valid from DECODE onward)
//   zero             ALU zero flag
//   mem_ready        memory completes the current access this cycle
//   mem_req/mem_we   memory request and its write qualifier
//   iord             memory address select (0 PC, 1 ALUOut)
//   ir_write         load IR
//   pc_write         unconditional PC load
//   pc_write_cond    PC load qualified by zero in the datapath
//   pc_source        00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a/b      ALU operand selects
//   alu_op           000 add, 001 sub, 010 or, 100 use funct
//   extop            1 sign-extend, 0 zero-extend
//   reg_write/reg_dst/mem_to_reg   register file write controls
//   illegal          sticky illegal-opcode flag
//   retired          retired-instruction count (wraps)
//   state            current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W           = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             extop,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_FUNCT = 3'b100;

    // Full strobe bundle, built in one place and driven out as a unit.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       extop;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    state_t st_q, st_d;
    ctrl_t  c;
    logic   retire;
    logic   set_ill;

    // funct is decoded by the ALU control unit, not here.
    logic unused_funct;
    assign unused_funct = ^funct;

    // ------------------------------------------------------------------
    // State, counter and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            st_q <= st_d;
            if (retire)  retired <= retired + 1'b1;
            if (set_ill) illegal <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        st_d     = FETCH;
        retire   = 1'b0;
        set_ill  = 1'b0;
        c        = '0;
        c.alu_op = ALU_ADD;
        c.extop  = 1'b1;

        case (st_q)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                // IR and PC+4 latch only on the cycle memory delivers.
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
                st_d        = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;   // branch target precompute
                case (op)
                    OP_RTYPE:      st_d = EXEC_R;
                    OP_ORI:        st_d = EXEC_I;
                    OP_LW, OP_SW:  st_d = MEM_ADDR;
                    OP_BEQ:        st_d = BRANCH;
                    OP_J:          st_d = JUMP;
                    default: begin
                        set_ill = 1'b1;
                        st_d    = TRAP_ON_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = ALU_FUNCT;
                st_d        = WB_R;
            end
            WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                retire      = 1'b1;
                st_d        = FETCH;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_OR;
                c.extop     = 1'b0;    // ORI zero-extends its immediate
                st_d        = WB_I;
            end
            WB_I: begin
                c.reg_write = 1'b1;
                retire      = 1'b1;
                st_d        = FETCH;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                // op is stable here; anything but SW is the LW path.
                st_d        = (op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                st_d      = mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                retire       = 1'b1;
                st_d         = FETCH;
            end
            MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
                retire    = mem_ready;
                st_d      = mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                // The zero qualification happens in the PC write enable.
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                retire          = 1'b1;
                st_d            = FETCH;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                retire      = 1'b1;
                st_d        = FETCH;
            end
            HALT: begin
                c    = '0;
                st_d = HALT;
            end
            default: begin
                // Unused encodings: quiet for one cycle, then recover.
                c    = '0;
                st_d = FETCH;
            end
        endcase

        // Strobes fall together with reset, not at the next clock, so an
        // interrupted memory write never sees a trailing cycle of mem_we.
        if (reset) c = '0;
    end

    assign mem_req       = c.mem_req;
    assign mem_we        = c.mem_we;
    assign iord          = c.iord;
    assign ir_write      = c.ir_write;
    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign pc_source     = c.pc_source;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign alu_op        = c.alu_op;
    assign extop         = c.extop;
    assign reg_write     = c.reg_write;
    assign reg_dst       = c.reg_dst;
    assign mem_to_reg    = c.mem_to_reg;
    assign state         = st_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Cycle-table bench for multicycle_control. Each table row gives the
//   inputs for one cycle and the state/strobes/flags expected in that
//   cycle; rows are pushed to a scoreboard when driven and popped when the
//   outputs are sampled. Hand sequences cover reset during a stalled store
//   and the illegal-opcode trap.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic        extop, reg_write, reg_dst, mem_to_reg, illegal;
    logic [31:0] retired;
    logic [3:0]  state;

    multicycle_control #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .extop(extop), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired),
        .state(state)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_cond,pc_source,
    //  alu_src_a,alu_src_b,alu_op,extop,reg_write,reg_dst,mem_to_reg}
    function automatic logic [17:0] sb(
        input logic mr, input logic we, input logic io, input logic irw,
        input logic pcw, input logic pcc, input logic [1:0] src,
        input logic a, input logic [1:0] b, input logic [2:0] aop,
        input logic ext, input logic rw, input logic rd, input logic m2r);
        return {mr, we, io, irw, pcw, pcc, src, a, b, aop, ext, rw, rd, m2r};
    endfunction

    logic [17:0] act_strb;
    assign act_strb = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                       pc_source, alu_src_a, alu_src_b, alu_op, extop,
                       reg_write, reg_dst, mem_to_reg};

    // Expected strobe words, one per state (FETCH split on mem_ready).
    logic [17:0] E_FW, E_FR, E_D, E_XR, E_WR, E_XI, E_WI, E_MA, E_RD, E_MW,
                 E_ST, E_BR, E_J, E_0;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] strb;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t scb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] o, input logic z,
                                input logic r, input logic [3:0] s,
                                input logic [17:0] e, input logic il,
                                input logic [31:0] rt);
        vec_t v;
        v.op = o; v.zero = z; v.rdy = r; v.st = s; v.strb = e;
        v.ill = il; v.ret = rt;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        op = v.op; zero = v.zero; mem_ready = v.rdy;
        scb.push_back(v);
        #1;
        e = scb.pop_front();
        check($sformatf("row%0d state", idx),   {28'd0, state}, {28'd0, e.st});
        check($sformatf("row%0d strobes", idx), {14'd0, act_strb}, {14'd0, e.strb});
        check($sformatf("row%0d illegal", idx), {31'd0, illegal}, {31'd0, e.ill});
        check($sformatf("row%0d retired", idx), retired, e.ret);
    endtask

    initial begin
        E_FW = sb(1,0,0,0,0,0,2'b00,0,2'b01,3'b000,1,0,0,0);
        E_FR = sb(1,0,0,1,1,0,2'b00,0,2'b01,3'b000,1,0,0,0);
        E_D  = sb(0,0,0,0,0,0,2'b00,0,2'b11,3'b000,1,0,0,0);
        E_XR = sb(0,0,0,0,0,0,2'b00,1,2'b00,3'b100,1,0,0,0);
        E_WR = sb(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,1,0);
        E_XI = sb(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
        E_WI = sb(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,0);
        E_MA = sb(0,0,0,0,0,0,2'b00,1,2'b10,3'b000,1,0,0,0);
        E_RD = sb(1,0,1,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,0);
        E_MW = sb(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,1);
        E_ST = sb(1,1,1,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,0);
        E_BR = sb(0,0,0,0,0,1,2'b01,1,2'b00,3'b001,1,0,0,0);
        E_J  = sb(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,1,0,0,0);
        E_0  = '0;

        // Fetch stall, then R-type (mem_ready high in non-memory states
        // must be ignored).
        vecs.push_back(mk(6'h00,0,0, 0,E_FW,0,0));
        vecs.push_back(mk(6'h00,0,0, 0,E_FW,0,0));
        vecs.push_back(mk(6'h00,0,1, 0,E_FR,0,0));
        vecs.push_back(mk(6'h00,0,1, 1,E_D ,0,0));
        vecs.push_back(mk(6'h00,0,1, 2,E_XR,0,0));
        vecs.push_back(mk(6'h00,0,1, 3,E_WR,0,0));
        // LW with a 3-cycle data stall.
        vecs.push_back(mk(6'h23,0,1, 0,E_FR,0,1));
        vecs.push_back(mk(6'h23,0,1, 1,E_D ,0,1));
        vecs.push_back(mk(6'h23,0,1, 6,E_MA,0,1));
        vecs.push_back(mk(6'h23,0,0, 7,E_RD,0,1));
        vecs.push_back(mk(6'h23,0,0, 7,E_RD,0,1));
        vecs.push_back(mk(6'h23,0,0, 7,E_RD,0,1));
        vecs.push_back(mk(6'h23,0,1, 7,E_RD,0,1));
        vecs.push_back(mk(6'h23,0,1, 8,E_MW,0,1));
        // BEQ taken, then not taken: same strobes, both retire.
        vecs.push_back(mk(6'h04,1,1, 0,E_FR,0,2));
        vecs.push_back(mk(6'h04,1,1, 1,E_D ,0,2));
        vecs.push_back(mk(6'h04,1,1,10,E_BR,0,2));
        vecs.push_back(mk(6'h04,0,1, 0,E_FR,0,3));
        vecs.push_back(mk(6'h04,0,1, 1,E_D ,0,3));
        vecs.push_back(mk(6'h04,0,1,10,E_BR,0,3));
        // ORI then J.
        vecs.push_back(mk(6'h0d,0,1, 0,E_FR,0,4));
        vecs.push_back(mk(6'h0d,0,1, 1,E_D ,0,4));
        vecs.push_back(mk(6'h0d,0,1, 4,E_XI,0,4));
        vecs.push_back(mk(6'h0d,0,1, 5,E_WI,0,4));
        vecs.push_back(mk(6'h02,0,1, 0,E_FR,0,5));
        vecs.push_back(mk(6'h02,0,1, 1,E_D ,0,5));
        vecs.push_back(mk(6'h02,0,1,11,E_J ,0,5));
        // SW with one wait cycle; retires only on the ready cycle.
        vecs.push_back(mk(6'h2b,0,1, 0,E_FR,0,6));
        vecs.push_back(mk(6'h2b,0,1, 1,E_D ,0,6));
        vecs.push_back(mk(6'h2b,0,1, 6,E_MA,0,6));
        vecs.push_back(mk(6'h2b,0,0, 9,E_ST,0,6));
        vecs.push_back(mk(6'h2b,0,1, 9,E_ST,0,6));
        vecs.push_back(mk(6'h2b,0,0, 0,E_FW,0,7));

        op = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
        reset = 1'b1;
        #12;
        check("reset state",   {28'd0, state}, 32'd0);
        check("reset strobes", {14'd0, act_strb}, {14'd0, E_0});
        check("reset illegal", {31'd0, illegal}, 32'd0);
        check("reset retired", retired, 32'd0);
        @(negedge clk); reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset while a store is stalled: strobes drop with reset.
        apply(mk(6'h2b,0,1, 0,E_FR,0,7), 100);
        apply(mk(6'h2b,0,1, 1,E_D ,0,7), 101);
        apply(mk(6'h2b,0,1, 6,E_MA,0,7), 102);
        apply(mk(6'h2b,0,0, 9,E_ST,0,7), 103);
        #1 reset = 1'b1;
        #1;
        check("async rst state",   {28'd0, state}, 32'd0);
        check("async rst mem_req", {31'd0, mem_req}, 32'd0);
        check("async rst mem_we",  {31'd0, mem_we}, 32'd0);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("post rst state",  {28'd0, state}, 32'd0);
            check("post rst iord",   {31'd0, iord}, 32'd0);
            check("post rst mem_we", {31'd0, mem_we}, 32'd0);
            check("post rst retired", retired, 32'd0);
        end

        // J, then an illegal opcode traps in HALT and stays quiet.
        apply(mk(6'h02,0,1, 0,E_FR,0,0), 200);
        apply(mk(6'h02,0,1, 1,E_D ,0,0), 201);
        apply(mk(6'h02,0,1,11,E_J ,0,0), 202);
        apply(mk(6'h3f,0,1, 0,E_FR,0,1), 203);
        apply(mk(6'h3f,0,1, 1,E_D ,0,1), 204);
        for (int k = 0; k < 4; k++)
            apply(mk(6'h3f,0,1,12,E_0,1,1), 205 + k);
        @(negedge clk); reset = 1'b1;
        #1;
        check("halt rst state",   {28'd0, state}, 32'd0);
        check("halt rst illegal", {31'd0, illegal}, 32'd0);
        check("halt rst retired", retired, 32'd0);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0;
        apply(mk(6'h00,0,0, 0,E_FW,0,0), 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
